// File: rtl/mem_sink.sv
`default_nettype none
// ============================================================================
// Module      : mem_sink
// Description : Memory-side consumer for the two-master path stage. Grants the
//               path after a fixed latency, limits burst length, stores each
//               valid word in a register-file memory and exposes a registered
//               host read port, fill count and sticky error flags.
//               Optional feature macro: MEM_SINK_CSUM_EN (running checksum of
//               accepted words on csum_o; tied to 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sink #(
   parameter int unsigned DWIDTH    = 8,
   parameter int unsigned AWIDTH    = 4,
   parameter int unsigned GNT_LAT   = 2,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_i,
   input  logic              valid_i,
   input  logic [DWIDTH-1:0] data_i,
   output logic              gnt_o,
   input  logic              clear_i,
   input  logic [AWIDTH-1:0] rd_addr_i,
   output logic [DWIDTH-1:0] rd_data_o,
   output logic [AWIDTH:0]   wr_cnt_o,
   output logic              full_o,
   output logic              overflow_o,
   output logic              proto_err_o,
   output logic [DWIDTH-1:0] csum_o
);

   localparam int unsigned     c_DEPTH     = 2**AWIDTH;
   localparam logic [AWIDTH:0] c_DEPTH_CNT = (AWIDTH+1)'(c_DEPTH);
   localparam logic [AWIDTH:0] c_LAST_CNT  = (AWIDTH+1)'(c_DEPTH - 1);
   localparam logic [3:0]      c_GNT_LAT   = 4'(GNT_LAT);
   localparam logic [3:0]      c_BURST_MAX = 4'(BURST_MAX);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_GRANT = 3'd2,
      ST_GAP   = 3'd3,
      ST_FULL  = 3'd4
   } state_t;

   state_t            r_state;
   logic [3:0]        r_lat_cnt;
   logic [3:0]        r_burst_cnt;
   logic              r_gnt;
   logic              r_gnt_q;
   logic [DWIDTH-1:0] r_mem [c_DEPTH];
   logic [AWIDTH-1:0] r_wr_ptr;
   logic [AWIDTH:0]   r_wr_cnt;
   logic              r_overflow;
   logic              r_proto_err;
   logic [DWIDTH-1:0] r_rd_data;

   logic              w_clr;
   logic              w_full;
   logic              w_wr_en;
   logic              w_fill;

   // Reset and clear act identically on everything except the read register
   assign w_clr   = rst_n | clear_i;
   assign w_full  = (r_wr_cnt == c_DEPTH_CNT);
   // Clear/reset outrank a coincident write, so that word is discarded
   assign w_wr_en = valid_i & ~w_full & ~w_clr;
   // This write takes the last free slot
   assign w_fill  = w_wr_en & (r_wr_cnt == c_LAST_CNT);

   // Grant FSM: latency count, burst limiting, forced gap, full lock-out
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_state     <= ST_IDLE;
         r_lat_cnt   <= 4'd0;
         r_burst_cnt <= 4'd0;
         r_gnt       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_fill) begin
                  r_state <= ST_FULL;
                  r_gnt   <= 1'b0;
               end else if (req_i && !w_full) begin
                  if (c_GNT_LAT == 4'd1) begin
                     r_state <= ST_GRANT;
                     r_gnt   <= 1'b1;
                  end else begin
                     r_state   <= ST_WAIT;
                     r_lat_cnt <= 4'd1;
                     r_gnt     <= 1'b0;
                  end
               end
            end
            ST_WAIT: begin
               if (w_fill) begin
                  r_state   <= ST_FULL;
                  r_lat_cnt <= 4'd0;
                  r_gnt     <= 1'b0;
               end else if (!req_i) begin
                  r_state   <= ST_IDLE;
                  r_lat_cnt <= 4'd0;
                  r_gnt     <= 1'b0;
               end else if (r_lat_cnt + 4'd1 == c_GNT_LAT) begin
                  r_state   <= ST_GRANT;
                  r_lat_cnt <= 4'd0;
                  r_gnt     <= 1'b1;
               end else begin
                  r_lat_cnt <= r_lat_cnt + 4'd1;
               end
            end
            ST_GRANT: begin
               // A fill beats a dropped request, which beats the burst limit
               if (w_fill) begin
                  r_state     <= ST_FULL;
                  r_burst_cnt <= 4'd0;
                  r_gnt       <= 1'b0;
               end else if (!req_i) begin
                  r_state     <= ST_IDLE;
                  r_burst_cnt <= 4'd0;
                  r_gnt       <= 1'b0;
               end else if (r_burst_cnt + 4'd1 == c_BURST_MAX) begin
                  r_state     <= ST_GAP;
                  r_burst_cnt <= 4'd0;
                  r_gnt       <= 1'b0;
               end else begin
                  r_burst_cnt <= r_burst_cnt + 4'd1;
                  r_gnt       <= 1'b1;
               end
            end
            ST_GAP: begin
               r_state <= w_fill ? ST_FULL : ST_IDLE;
               r_gnt   <= 1'b0;
            end
            ST_FULL: begin
               r_gnt <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= 1'b0;
            end
         endcase
      end
   end

   // Write bookkeeping: pointer, fill count, sticky overflow and protocol flags
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_wr_ptr    <= '0;
         r_wr_cnt    <= '0;
         r_overflow  <= 1'b0;
         r_proto_err <= 1'b0;
         r_gnt_q     <= 1'b0;
      end else begin
         // Grant as seen by the path one cycle before its valid
         r_gnt_q <= r_gnt;
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_wr_cnt <= r_wr_cnt + 1'b1;
         end
         if (valid_i && w_full) begin
            r_overflow <= 1'b1;
         end
         if (valid_i && !r_gnt_q) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   // Storage array; contents survive reset and clear
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   // Host read port; keeps tracking the address through clear
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[rd_addr_i];
      end
   end

`ifdef MEM_SINK_CSUM_EN
   logic [DWIDTH-1:0] r_csum;

   // Running modular sum of accepted words only
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_csum <= '0;
      end else if (w_wr_en) begin
         r_csum <= r_csum + data_i;
      end
   end

   assign csum_o = r_csum;
`else
   assign csum_o = '0;
`endif

   assign gnt_o       = r_gnt;
   assign rd_data_o   = r_rd_data;
   assign wr_cnt_o    = r_wr_cnt;
   assign full_o      = w_full;
   assign overflow_o  = r_overflow;
   assign proto_err_o = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_sink
// Description : Directed self-checking bench for mem_sink (default parameters)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sink;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_i;
   logic       valid_i;
   logic [7:0] data_i;
   logic       gnt_o;
   logic       clear_i;
   logic [3:0] rd_addr_i;
   logic [7:0] rd_data_o;
   logic [4:0] wr_cnt_o;
   logic       full_o;
   logic       overflow_o;
   logic       proto_err_o;
   logic [7:0] csum_o;

   int         n_pass   = 0;
   int         n_checks = 0;

   logic       r_prev_g;
   int         r_n_words;
   logic [7:0] r_exp_mem [16];
   logic [7:0] r_exp_csum;
   logic [13:0] r_hist;

   mem_sink #(
      .DWIDTH    (8),
      .AWIDTH    (4),
      .GNT_LAT   (2),
      .BURST_MAX (4)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_i),
      .valid_i     (valid_i),
      .data_i      (data_i),
      .gnt_o       (gnt_o),
      .clear_i     (clear_i),
      .rd_addr_i   (rd_addr_i),
      .rd_data_o   (rd_data_o),
      .wr_cnt_o    (wr_cnt_o),
      .full_o      (full_o),
      .overflow_o  (overflow_o),
      .proto_err_o (proto_err_o),
      .csum_o      (csum_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Path model: valid follows grant by one cycle, words are 0x11, 0x22, ...
   task automatic path_cycles(input int ncyc, input int stop_at);
      for (int c = 0; c < ncyc; c++) begin
         if (r_prev_g && r_n_words < stop_at) begin
            valid_i = 1'b1;
            data_i  = 8'((r_n_words + 1) * 17);
            r_exp_mem[r_n_words] = data_i;
            r_exp_csum = r_exp_csum + data_i;
            r_n_words++;
         end else begin
            valid_i = 1'b0;
         end
         r_prev_g = gnt_o;
         r_hist   = {r_hist[12:0], gnt_o};
         tick();
      end
      valid_i = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [3:0] addr, input logic [7:0] exp);
      rd_addr_i = addr;
      tick();
      check(tag, 32'(rd_data_o), 32'(exp));
   endtask

   function automatic logic [7:0] csum_exp(input logic [7:0] v);
`ifdef MEM_SINK_CSUM_EN
      return v;
`else
      return 8'h00 & v;
`endif
   endfunction

   initial begin
      rst_n      = 1'b1;
      req_i      = 1'b1;
      valid_i    = 1'b0;
      data_i     = 8'h00;
      clear_i    = 1'b0;
      rd_addr_i  = 4'd0;
      r_prev_g   = 1'b0;
      r_n_words  = 0;
      r_exp_csum = 8'h00;
      r_hist     = '0;

      // Reset with req held
      tick(); tick(); tick();
      check("rst_gnt",      32'(gnt_o),       32'd0);
      check("rst_wr_cnt",   32'(wr_cnt_o),    32'd0);
      check("rst_full",     32'(full_o),      32'd0);
      check("rst_overflow", 32'(overflow_o),  32'd0);
      check("rst_proto",    32'(proto_err_o), 32'd0);
      check("rst_rd_data",  32'(rd_data_o),   32'd0);
      check("rst_csum",     32'(csum_o),      32'd0);

      rst_n = 1'b0;
      tick();
      check("lat_gnt_e0", 32'(gnt_o), 32'd0);
      tick();
      check("lat_gnt_e1", 32'(gnt_o), 32'd1);

      // Burst pattern with lagging valid
      r_prev_g = 1'b0;
      path_cycles(14, 16);
      check("burst_pattern", 32'(r_hist), 32'(14'b11110001111000));
      check("wr_cnt_8",      32'(wr_cnt_o), 32'd8);
      check("proto_clean",   32'(proto_err_o), 32'd0);

      // Fill to 16 words
      path_cycles(30, 16);
      check("words_sent",  32'(r_n_words), 32'd16);
      check("full_set",    32'(full_o),    32'd1);
      check("full_cnt",    32'(wr_cnt_o),  32'd16);
      check("full_gnt",    32'(gnt_o),     32'd0);
      check("full_no_ovf", 32'(overflow_o), 32'd0);
      check("full_csum",   32'(csum_o),    32'(csum_exp(r_exp_csum)));

      // Overflow word
      valid_i = 1'b1;
      data_i  = 8'hAA;
      tick();
      valid_i = 1'b0;
      check("ovf_set",    32'(overflow_o), 32'd1);
      check("ovf_cnt",    32'(wr_cnt_o),   32'd16);
      check("ovf_csum",   32'(csum_o),     32'(csum_exp(r_exp_csum)));
      tick();
      check("ovf_gnt",    32'(gnt_o),      32'd0);
      for (int a = 0; a < 16; a++) begin
         read_check($sformatf("mem_%0d", a), 4'(a), r_exp_mem[a]);
      end

      // Clear with a coincident write while full
      clear_i = 1'b1;
      valid_i = 1'b1;
      data_i  = 8'h77;
      tick();
      clear_i = 1'b0;
      valid_i = 1'b0;
      check("clr_cnt",   32'(wr_cnt_o),    32'd0);
      check("clr_full",  32'(full_o),      32'd0);
      check("clr_ovf",   32'(overflow_o),  32'd0);
      check("clr_proto", 32'(proto_err_o), 32'd0);
      check("clr_gnt",   32'(gnt_o),       32'd0);
      check("clr_csum",  32'(csum_o),      32'd0);
      tick();
      check("clr_regnt_e0", 32'(gnt_o), 32'd0);
      tick();
      check("clr_regnt_e1", 32'(gnt_o), 32'd1);
      req_i = 1'b0;
      tick();
      check("req_drop_gnt", 32'(gnt_o), 32'd0);

      // Clear with a coincident write while not full: word must not land
      clear_i = 1'b1;
      valid_i = 1'b1;
      data_i  = 8'h77;
      tick();
      clear_i = 1'b0;
      valid_i = 1'b0;
      check("clr2_cnt", 32'(wr_cnt_o), 32'd0);
      read_check("clr2_mem0", 4'd0, 8'h11);

      // Valid without a grant
      tick(); tick(); tick();
      valid_i = 1'b1;
      data_i  = 8'h5C;
      tick();
      valid_i = 1'b0;
      check("proto_set", 32'(proto_err_o), 32'd1);
      check("proto_cnt", 32'(wr_cnt_o),    32'd1);
      tick(); tick();
      check("proto_sticky", 32'(proto_err_o), 32'd1);
      read_check("proto_mem0", 4'd0, 8'h5C);
      check("proto_csum", 32'(csum_o), 32'(csum_exp(8'h5C)));

      // Checksum wrap
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      valid_i = 1'b1;
      data_i  = 8'hF0;
      tick();
      data_i  = 8'h20;
      tick();
      data_i  = 8'h01;
      tick();
      valid_i = 1'b0;
      check("csum_cnt", 32'(wr_cnt_o), 32'd3);
      check("csum_val", 32'(csum_o),   32'(csum_exp(8'h11)));

      // Reset mid-burst with a coincident word
      req_i = 1'b1;
      tick(); tick();
      check("mid_gnt", 32'(gnt_o), 32'd1);
      rst_n   = 1'b1;
      valid_i = 1'b1;
      data_i  = 8'h99;
      tick();
      rst_n   = 1'b0;
      valid_i = 1'b0;
      req_i   = 1'b0;
      check("mid_rst_gnt",   32'(gnt_o),       32'd0);
      check("mid_rst_cnt",   32'(wr_cnt_o),    32'd0);
      check("mid_rst_proto", 32'(proto_err_o), 32'd0);
      check("mid_rst_csum",  32'(csum_o),      32'd0);
      read_check("mid_rst_mem3", 4'd3, 8'h44);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_sink.md
Name: mem_sink

Overview:
- Memory-side consumer directly downstream of the two-master path/FIFO stage.
- Answers the path's req with a grant (gnt), and captures each word the path sends with valid.
- Stores accepted words in an internal register-file memory. A host reads them back through a synchronous read port.
- Grant policy adds a fixed latency, a maximum burst length, and back-pressure when the memory is full.

Parameters:
DWIDTH, 8, data word width
AWIDTH, 4, memory address width; depth = 2**AWIDTH words
GNT_LAT, 2, cycles from sampled req_i to gnt_o high; legal range 1..15
BURST_MAX, 4, max consecutive grant cycles before a forced 1-cycle gap; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-high: asserted when 1
req_i  in  1  request from path stage (its req_o)
valid_i  in  1  data valid from path stage (its valid_o)
data_i  in  DWIDTH  data from path stage (its data_o)
gnt_o  out  1  grant to path stage (its gnt_i); registered
clear_i  in  1  pulse: empties memory, clears flags
rd_addr_i  in  AWIDTH  host read address
rd_data_o  out  DWIDTH  mem[rd_addr_i], registered, 1-cycle latency
wr_cnt_o  out  AWIDTH+1  number of words stored
full_o  out  1  wr_cnt_o == 2**AWIDTH
overflow_o  out  1  sticky: valid_i seen while full
proto_err_o  out  1  sticky: valid_i with gnt_o low in the previous cycle
csum_o  out  DWIDTH  checksum (see Optional Feature)

Behaviour:
Reset and clear
- Reset (rst_n==1 at a clk edge) sets every output to 0, the FSM to IDLE, and all counters and pointers to 0. Memory contents are not reset.
- Reset mid-burst drops gnt_o on the next edge. A word arriving in that same cycle is discarded.
- clear_i==1 (no reset) does the same as reset, except rd_data_o keeps updating.
- clear_i has priority over a simultaneous write, so that write is discarded.

FSM (state register; gnt_o = 1 exactly when the state is GRANT)
- IDLE:
  - req_i & !full_o -> WAIT, with lat_cnt=1; if GNT_LAT==1, go straight to GRANT.
  - Otherwise stay in IDLE.
- WAIT:
  - lat_cnt increments each cycle; when lat_cnt==GNT_LAT, go to GRANT.
  - If req_i drops, return to IDLE.
- GRANT: burst_cnt increments each cycle. Exit priority, highest first:
  1. The accepted write makes memory full -> FULL.
  2. req_i==0 -> IDLE.
  3. burst_cnt==BURST_MAX -> GAP.
  4. Otherwise stay in GRANT.
  - burst_cnt clears on any exit.
- GAP: exactly 1 cycle with gnt_o=0, then IDLE. req_i is re-evaluated from IDLE, so minimum re-grant time = 1 + GNT_LAT cycles.
- FULL: gnt_o=0. Leave only on clear_i or reset.

Write path (independent of FSM state)
- Each edge with valid_i==1:
  - If !full_o: mem[wr_ptr] <= data_i, wr_ptr+1 (wraps only via clear), wr_cnt_o+1.
  - If full_o: word dropped, overflow_o <= 1.
- If gnt_o was 0 in the previous cycle (the path registers valid one cycle after grant), set proto_err_o <= 1. The word is still written.
- Accepted words are readable at rd_addr_i the cycle after the write edge. A read of the same address in the write cycle returns the old data.
- wr_cnt_o saturates at 2**AWIDTH.

Optional Feature:
MEM_SINK_CSUM_EN
- Defined: csum_o = running sum modulo 2**DWIDTH of every accepted data_i.
  - Updates on the write edge.
  - Cleared by reset/clear_i.
  - Dropped (overflow) words are excluded.
- Undefined: csum_o tied to 0, and no adder logic is synthesised.

Test Plan:
1. Reset with req_i=1 held -> gnt_o=0 during reset. After release, gnt_o rises exactly GNT_LAT=2 cycles after the first sampled req_i.
2. req_i held high, valid_i=1 one cycle after each grant cycle, data 0x11,0x22,... -> gnt_o high 4 cycles, low 1 cycle (GAP), low 2 more (WAIT), then high again. Memory stores 0x11..0x88 in order; wr_cnt_o=8 after 8 words.
3. Fill to 16 words -> full_o=1 and gnt_o falls the edge after the 16th write. An extra valid_i with 0xAA sets overflow_o=1, wr_cnt_o stays 16, and mem[0] is unchanged.
4. clear_i pulse with valid_i=1 in the same cycle -> wr_cnt_o=0, full_o=0, overflow_o=0, FSM in IDLE. The word is not stored, and a new req_i is granted after GNT_LAT.
5. valid_i=1 (data 0x5C) while gnt_o has been low for 3 cycles -> proto_err_o=1 (sticky); 0x5C is readable at address wr_ptr-1.
6. With MEM_SINK_CSUM_EN: write 0xF0, 0x20, 0x01 -> csum_o=0x11. Without the macro, csum_o=0 throughout.
